// File: rtl/pcs_10g_block_sync.sv
// pcs_10g_block_sync: 64b/66b RX block-lock stage (Clause 49 lock state machine).
// Tests each block's 2-bit sync header, pulses rx_slip to realign the upstream
// gearbox until lock, and forwards every block with one cycle of latency.
// Optional: define BLOCK_SYNC_STATS_EN to add saturating slip/lock-loss counters.
module pcs_10g_block_sync #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [65:0] rx_block_in,
  input  logic        rx_block_valid,
  output logic        rx_slip,
  output logic        block_lock,
  output logic [65:0] rx_block_out,
  output logic        rx_block_out_valid,
  output logic        sh_invalid
`ifdef BLOCK_SYNC_STATS_EN
  ,
  output logic [15:0] slip_count,
  output logic [15:0] lock_loss_count
`endif
);

  localparam int CNT_W     = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W     = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W    = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int WAIT_LAST = (SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0;

  typedef enum logic [1:0] {
    RESET_CNT,
    TEST_SH,
    SLIP_HOLD
  } state_e;

  state_e              state_q, state_d;
  state_e              hold_next;
  logic [CNT_W-1:0]    sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [INV_W-1:0]    sh_invld_cnt_q, sh_invld_cnt_d, sh_invld_inc;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                block_lock_q, block_lock_d;
  logic                rx_slip_q, rx_slip_d;
  logic [65:0]         rx_block_q;
  logic                rx_block_valid_q;
  logic                sh_invalid_q;
  logic                hdr_bad;

  // Headers 2'b01 and 2'b10 are legal; 2'b00 and 2'b11 are not.
  assign hdr_bad      = ~(rx_block_in[65] ^ rx_block_in[64]);
  assign sh_cnt_inc   = sh_cnt_q + CNT_W'(1);
  assign sh_invld_inc = sh_invld_cnt_q + INV_W'(hdr_bad);
  // With no realignment wait the hold state is skipped entirely.
  assign hold_next    = (SLIP_WAIT == 0) ? RESET_CNT : SLIP_HOLD;

  // Lock FSM next-state, counter updates and slip request.
  always_comb begin
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    block_lock_d   = block_lock_q;
    rx_slip_d      = 1'b0;
    case (state_q)
      RESET_CNT: begin
        sh_cnt_d       = '0;
        sh_invld_cnt_d = '0;
        wait_cnt_d     = '0;
        state_d        = TEST_SH;
      end
      TEST_SH: begin
        if (rx_block_valid) begin
          sh_cnt_d       = sh_cnt_inc;
          sh_invld_cnt_d = sh_invld_inc;
          if (block_lock_q) begin
            // Invalid threshold wins over a coincident window end.
            if (sh_invld_inc == INV_W'(SH_INVLD_MAX)) begin
              block_lock_d = 1'b0;
              rx_slip_d    = 1'b1;
              state_d      = hold_next;
            end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              state_d = RESET_CNT;
            end
          end else begin
            if (hdr_bad) begin
              rx_slip_d = 1'b1;
              state_d   = hold_next;
            end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              block_lock_d = 1'b1;
              state_d      = RESET_CNT;
            end
          end
        end
      end
      SLIP_HOLD: begin
        if (rx_block_valid) begin
          if (wait_cnt_q == WAIT_W'(WAIT_LAST)) begin
            wait_cnt_d = '0;
            state_d    = RESET_CNT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      default: state_d = RESET_CNT;
    endcase
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RESET_CNT;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      wait_cnt_q     <= '0;
      block_lock_q   <= 1'b0;
      rx_slip_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      block_lock_q   <= block_lock_d;
      rx_slip_q      <= rx_slip_d;
    end
  end

  // Lock-independent forwarding datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_block_q       <= '0;
      rx_block_valid_q <= 1'b0;
      sh_invalid_q     <= 1'b0;
    end else begin
      if (rx_block_valid) rx_block_q <= rx_block_in;
      rx_block_valid_q <= rx_block_valid;
      sh_invalid_q     <= rx_block_valid & hdr_bad;
    end
  end

`ifdef BLOCK_SYNC_STATS_EN
  logic [15:0] slip_count_q;
  logic [15:0] lock_loss_count_q;

  // Saturating slip and lock-loss event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slip_count_q      <= '0;
      lock_loss_count_q <= '0;
    end else begin
      if (rx_slip_d && (slip_count_q != '1))
        slip_count_q <= slip_count_q + 16'd1;
      if (block_lock_q && !block_lock_d && (lock_loss_count_q != '1))
        lock_loss_count_q <= lock_loss_count_q + 16'd1;
    end
  end

  assign slip_count      = slip_count_q;
  assign lock_loss_count = lock_loss_count_q;
`endif

  assign rx_slip            = rx_slip_q;
  assign block_lock         = block_lock_q;
  assign rx_block_out       = rx_block_q;
  assign rx_block_out_valid = rx_block_valid_q;
  assign sh_invalid         = sh_invalid_q;

endmodule

// File: tb/tb_pcs_10g_block_sync.sv
// Self-checking bench for pcs_10g_block_sync: directed lock/slip scenarios plus
// random traffic, compared every cycle against a window-level reference model.
module tb_pcs_10g_block_sync;

  localparam int SH_CNT_MAX   = 64;
  localparam int SH_INVLD_MAX = 16;
  localparam int SLIP_WAIT    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [65:0] rx_block_in = '0;
  logic        rx_block_valid = 1'b0;
  logic        rx_slip;
  logic        block_lock;
  logic [65:0] rx_block_out;
  logic        rx_block_out_valid;
  logic        sh_invalid;
`ifdef BLOCK_SYNC_STATS_EN
  logic [15:0] slip_count;
  logic [15:0] lock_loss_count;
`endif

  pcs_10g_block_sync #(
    .SH_CNT_MAX  (SH_CNT_MAX),
    .SH_INVLD_MAX(SH_INVLD_MAX),
    .SLIP_WAIT   (SLIP_WAIT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_block_in       (rx_block_in),
    .rx_block_valid    (rx_block_valid),
    .rx_slip           (rx_slip),
    .block_lock        (block_lock),
    .rx_block_out      (rx_block_out),
    .rx_block_out_valid(rx_block_out_valid),
    .sh_invalid        (sh_invalid)
`ifdef BLOCK_SYNC_STATS_EN
    ,
    .slip_count        (slip_count),
    .lock_loss_count   (lock_loss_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dut_slips = 0;

  // Reference model: a window of headers is being tallied unless the model is
  // in its post-window clear cycle (m_rearm) or discarding blocks after a slip.
  bit          m_lock, m_rearm, m_slip, m_out_v, m_shinv;
  int          m_discard, m_seen, m_bad, m_slips, m_losses;
  logic [65:0] m_out;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_rearm = 1; m_slip = 0; m_out_v = 0; m_shinv = 0;
    m_discard = 0; m_seen = 0; m_bad = 0; m_slips = 0; m_losses = 0;
    m_out = '0;
  endtask

  task automatic lose_alignment();
    m_slip = 1;
    m_slips++;
    if (SLIP_WAIT == 0) m_rearm = 1;
    else m_discard = SLIP_WAIT;
  endtask

  task automatic model_step(input bit v, input logic [65:0] blk_in);
    bit bad;
    bad = (blk_in[65:64] == 2'b00) || (blk_in[65:64] == 2'b11);
    m_slip  = 0;
    m_out_v = v;
    m_shinv = v && bad;
    if (v) m_out = blk_in;
    if (m_rearm) begin
      m_rearm = 0; m_seen = 0; m_bad = 0; m_discard = 0;
    end else if (m_discard > 0) begin
      if (v) begin
        m_discard--;
        if (m_discard == 0) m_rearm = 1;
      end
    end else if (v) begin
      m_seen++;
      if (bad) m_bad++;
      if (m_lock && m_bad >= SH_INVLD_MAX) begin
        m_lock = 0;
        m_losses++;
        lose_alignment();
      end else if (!m_lock && m_bad > 0) begin
        lose_alignment();
      end else if (m_seen >= SH_CNT_MAX) begin
        m_lock  = 1;
        m_rearm = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("block_lock", block_lock, m_lock);
    check("rx_slip", rx_slip, m_slip);
    check("rx_block_out", rx_block_out, m_out);
    check("rx_block_out_valid", rx_block_out_valid, m_out_v);
    check("sh_invalid", sh_invalid, m_shinv);
`ifdef BLOCK_SYNC_STATS_EN
    check("slip_count", slip_count, m_slips);
    check("lock_loss_count", lock_loss_count, m_losses);
`endif
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  // One clock: drive inputs, step the model on the edge, compare 1 time unit later.
  task automatic blk(input bit v, input logic [1:0] hdr);
    rx_block_in    = {hdr, $urandom(), $urandom()};
    rx_block_valid = v;
    @(posedge clk);
    model_step(v, rx_block_in);
    #1;
    if (rx_slip === 1'b1) dut_slips++;
    compare_all();
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++) blk(1'b1, good_hdr());
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    rst_n          = 1'b0;
    rx_block_valid = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    dut_slips = 0;
  endtask

  // One 64-block window with nbad invalid headers at random positions;
  // last_bad forces the final block of the window to be one of them.
  task automatic window(input int nbad, input bit last_bad);
    bit pos [SH_CNT_MAX];
    int placed;
    int p;
    for (int i = 0; i < SH_CNT_MAX; i++) pos[i] = 0;
    placed = 0;
    if (last_bad) begin
      pos[SH_CNT_MAX-1] = 1;
      placed = 1;
    end
    while (placed < nbad) begin
      p = $urandom_range(0, SH_CNT_MAX - 2);
      if (!pos[p]) begin
        pos[p] = 1;
        placed++;
      end
    end
    for (int i = 0; i < SH_CNT_MAX; i++) blk(1'b1, pos[i] ? bad_hdr() : good_hdr());
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // 1: clear cycle after reset, then 64 good headers gain lock.
    blk(1'b1, good_hdr());
    good(SH_CNT_MAX - 1);
    check("t1_prelock", block_lock, 1'b0);
    good(1);
    check("t1_lock", block_lock, 1'b1);
    check("t1_no_slip", dut_slips, 0);

    // 3: 15 invalid headers in one window keep lock.
    blk(1'b1, good_hdr());
    window(SH_INVLD_MAX - 1, 1'b0);
    check("t3_lock_held", block_lock, 1'b1);

    // 4: 16th invalid on the 64th block of the window loses lock.
    blk(1'b1, good_hdr());
    window(SH_INVLD_MAX, 1'b1);
    check("t4_lock_lost", block_lock, 1'b0);
    check("t4_slip", rx_slip, 1'b1);
    check("t4_slip_count", dut_slips, 1);

    // 6: reset while discarding after the slip.
    blk(1'b1, good_hdr());
    do_reset();
    check("t6_lock_clear", block_lock, 1'b0);
    blk(1'b1, good_hdr());
    good(SH_CNT_MAX - 1);
    check("t6_prelock", block_lock, 1'b0);
    good(1);
    check("t6_relock", block_lock, 1'b1);

    // 2: unlocked, block 10 invalid; following discarded blocks are bad on purpose.
    do_reset();
    blk(1'b1, good_hdr());
    good(9);
    blk(1'b1, bad_hdr());
    check("t2_slip", rx_slip, 1'b1);
    for (int i = 0; i < SLIP_WAIT + 1; i++) blk(1'b1, bad_hdr());
    check("t2_one_slip", dut_slips, 1);
    good(SH_CNT_MAX - 1);
    check("t2_prelock", block_lock, 1'b0);
    good(1);
    check("t2_lock", block_lock, 1'b1);

    // 5: idle gaps between good blocks do not disturb the count.
    do_reset();
    blk(1'b1, good_hdr());
    for (int i = 0; i < SH_CNT_MAX; i++) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) blk(1'b0, $urandom_range(0, 3));
      if (i == SH_CNT_MAX - 1) check("t5_prelock", block_lock, 1'b0);
      blk(1'b1, good_hdr());
    end
    check("t5_lock", block_lock, 1'b1);

    // Random traffic: low error rate, then heavy bursts, then low again.
    for (int i = 0; i < 2500; i++)
      blk($urandom_range(0, 9) < 7, ($urandom_range(0, 199) == 0) ? bad_hdr() : good_hdr());
    for (int i = 0; i < 800; i++)
      blk($urandom_range(0, 9) < 8, ($urandom_range(0, 3) == 0) ? bad_hdr() : good_hdr());
    for (int i = 0; i < 1500; i++)
      blk($urandom_range(0, 9) < 9, ($urandom_range(0, 299) == 0) ? bad_hdr() : good_hdr());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcs_10g_block_sync.md
Name: pcs_10g_block_sync

Overview:
- RX 64b/66b block-lock stage, per IEEE 802.3 Clause 49.2.13.2.2.
- Sits between the RX gearbox (upstream) and pcs_10g_descrambler (downstream).
- Checks the 2-bit sync header of each 66-bit word and runs the lock state machine.
- Pulses rx_slip so the gearbox shifts its 66-bit alignment by one bit until lock.
- Forwards every block to the descrambler with a 1-cycle registered latency.

Parameters:
- SH_CNT_MAX, 64, number of headers per test window.
- SH_INVLD_MAX, 16, invalid headers in one window that cause loss of lock.
- SLIP_WAIT, 2, valid blocks ignored after a slip while the gearbox realigns (0 allowed).

Ports:
- clk  in  1  core clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- rx_block_in  in  66  raw block from gearbox; [65:64] = sync header, [63:0] = scrambled payload.
- rx_block_valid  in  1  rx_block_in is valid this cycle.
- rx_slip  out  1  one-cycle pulse: gearbox shifts alignment by one bit.
- block_lock  out  1  Clause 49 block_lock status.
- rx_block_out  out  66  registered copy of rx_block_in.
- rx_block_out_valid  out  1  registered copy of rx_block_valid.
- sh_invalid  out  1  registered flag: forwarded block had header 2'b00 or 2'b11.

Behaviour:
Reset values:
- All outputs 0.
- sh_cnt = 0, sh_invld_cnt = 0, slip-wait counter = 0.
- State = RESET_CNT.

Datapath:
- On every cycle: rx_block_out <= rx_block_in when valid; rx_block_out_valid <= rx_block_valid.
- sh_invalid <= valid & (hdr == 2'b00 | hdr == 2'b11).
- The datapath ignores lock state; downstream qualifies with block_lock.
- Cycles with rx_block_valid = 0: FSM and counters hold, except rx_slip, which is a single-cycle pulse.

Header test on each valid block (unless in SLIP_HOLD):
- sh_cnt++.
- Invalid header → sh_invld_cnt++.
- Counters are 7-bit and 5-bit; no wrap, because they are always reset at the window limits below.

FSM states: RESET_CNT, TEST_SH, SLIP_HOLD.
- RESET_CNT: clear both counters; go to TEST_SH next cycle. No header test this cycle; a valid block here is forwarded but not counted.
- TEST_SH, block_lock = 0:
  - Any invalid header → rx_slip = 1 for one cycle, go to SLIP_HOLD.
  - sh_cnt reaches SH_CNT_MAX with sh_invld_cnt = 0 → block_lock <= 1, go to RESET_CNT.
- TEST_SH, block_lock = 1:
  - sh_invld_cnt reaches SH_INVLD_MAX (checked on the counting block, before the window end) → block_lock <= 0, rx_slip pulse, go to SLIP_HOLD.
  - Otherwise, sh_cnt reaches SH_CNT_MAX → go to RESET_CNT, lock retained.
- SLIP_HOLD: discard (do not count) SLIP_WAIT valid blocks, then go to RESET_CNT.
- Simultaneous events: the invalid-threshold test has priority over the window-end test. The 64th block being the 16th invalid header → lock lost.
- rx_slip is asserted in the cycle after the offending block is sampled (registered output).
- Reset asserted mid-operation: immediate return to reset values, including an in-flight rx_slip.

Optional Feature:
BLOCK_SYNC_STATS_EN
- Defined: adds output ports slip_count[15:0] and lock_loss_count[15:0].
  - Both are saturating at 16'hFFFF and cleared by rst_n.
  - slip_count increments on each rx_slip pulse.
  - lock_loss_count increments on each 1→0 transition of block_lock.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
1. Reset, then 64 valid blocks with hdr 2'b01 → block_lock = 1 after the 64th block is sampled; rx_slip never asserted; rx_block_out equals rx_block_in delayed 1 cycle.
2. Unlocked; block 10 has hdr 2'b11 → one rx_slip pulse; next 2 valid blocks ignored; counting restarts; 64 further good headers → lock.
3. Locked; 15 invalid headers spread across one 64-block window → lock held; window restarts with counters cleared.
4. Locked; 16 invalid headers within one window → block_lock drops on the 16th; rx_slip pulses once; with the macro defined, lock_loss_count = 1 and slip_count = 1.
5. Gaps with rx_block_valid = 0 between good blocks → counts unaffected; lock still reached after exactly 64 valid blocks.
6. rst_n asserted in SLIP_HOLD with block_lock = 1 previously → all outputs 0 immediately; relock requires 64 good headers.
